// File: rtl/model_cpu_pkg.sv
// Shared definitions for the model computer's program-ROM fetch path:
// opcode values, fetch FSM states and opcode classification helpers.
package model_cpu_pkg;

   localparam logic [7:0] OP_LD   = 8'hFF;
   localparam logic [7:0] OP_ADD  = 8'hFE;
   localparam logic [7:0] OP_SUB  = 8'hFD;
   localparam logic [7:0] OP_AND  = 8'hFC;
   localparam logic [7:0] OP_OR   = 8'hFB;
   localparam logic [7:0] OP_XOR  = 8'hF2;
   localparam logic [7:0] OP_SHL  = 8'hF9;
   localparam logic [7:0] OP_HALT = 8'hF8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_OP,
      S_FETCH_ARG,
      S_ISSUE,
      S_HALT,
      S_ERR
   } fetch_state_t;

   function automatic logic is_two_byte(input logic [7:0] op);
      case (op)
         OP_LD, OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR, OP_SHL: return 1'b1;
         default:               return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [7:0] op);
      return is_two_byte(op) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/fetch_op_decode.sv
// Combinational opcode classifier: legal / two-byte / halt.
import model_cpu_pkg::*;

module fetch_op_decode #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] i_op,
   output logic          o_legal,
   output logic          o_two_byte,
   output logic          o_halt
);

   logic [7:0] w_lo;
   logic       w_hi_zero;

   // Opcodes are byte values; any set bit above bit 7 makes the word illegal.
   assign w_lo       = i_op[7:0];
   assign w_hi_zero  = ((i_op >> 8) == '0);
   assign o_legal    = w_hi_zero && is_legal(w_lo);
   assign o_two_byte = w_hi_zero && is_two_byte(w_lo);
   assign o_halt     = w_hi_zero && (w_lo == OP_HALT);

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Program-ROM bus master: fetches opcode/operand pairs and hands them to
// the execute stage on a valid/ready handshake; stops on HALT or bad opcode.
import model_cpu_pkg::*;

module rom_fetch_ctrl #(
   parameter int AW          = 4,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   output logic          CE,
   output logic [AW-1:0] ABUS,
   input  logic [DW-1:0] DBUS,
   output logic          INSTR_VALID,
   input  logic          INSTR_READY,
   output logic [DW-1:0] OPCODE,
   output logic [DW-1:0] OPERAND,
   output logic [AW-1:0] PC,
   output logic          HALTED,
   output logic          ERROR
);

   localparam int            CW   = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   fetch_state_t  r_state;
   fetch_state_t  w_next;
   logic          r_ce;
   logic [AW-1:0] r_abus;
   logic [AW-1:0] r_pc;
   logic [CW-1:0] r_cnt;
   logic          r_valid;
   logic [DW-1:0] r_opcode;
   logic [DW-1:0] r_operand;
   logic          r_halted;
   logic          r_error;

   logic          w_last;
   logic          w_legal;
   logic          w_two;
   logic          w_halt_in;
   logic          w_is_halt;
   logic [AW-1:0] w_pc_inc;

   fetch_op_decode #(.DW(DW)) u_dec (
      .i_op       (DBUS),
      .o_legal    (w_legal),
      .o_two_byte (w_two),
      .o_halt     (w_halt_in)
   );

   assign w_last    = (r_cnt == LAST);
   assign w_pc_inc  = r_pc + 1'b1;
   assign w_is_halt = (r_opcode == DW'(OP_HALT));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (START) w_next = S_FETCH_OP;
         end
         S_FETCH_OP: begin
            if (w_last) begin
               if (!w_legal)       w_next = S_ERR;
               else if (w_two)     w_next = S_FETCH_ARG;
               else if (w_halt_in) w_next = S_ISSUE;
               else                w_next = S_ERR;
            end
         end
         S_FETCH_ARG: begin
            if (w_last) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (INSTR_READY) w_next = w_is_halt ? S_HALT : S_FETCH_OP;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_ce      <= 1'b1;
         r_abus    <= '0;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_opcode  <= '0;
         r_operand <= '0;
         r_halted  <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_ce   <= 1'b0;
                  r_abus <= r_pc;
                  r_cnt  <= '0;
               end
            end
            S_FETCH_OP: begin
               if (w_last) begin
                  r_opcode <= DBUS;
                  r_pc     <= w_pc_inc;
                  r_cnt    <= '0;
                  if (!w_legal) begin
                     r_ce    <= 1'b1;
                     r_error <= 1'b1;
                  end else if (w_two) begin
                     r_abus <= w_pc_inc;
                  end else begin
                     r_ce      <= 1'b1;
                     r_operand <= '0;
                     r_valid   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_FETCH_ARG: begin
               if (w_last) begin
                  r_operand <= DBUS;
                  r_pc      <= w_pc_inc;
                  r_cnt     <= '0;
                  r_ce      <= 1'b1;
                  r_valid   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_ISSUE: begin
               // Accepting edge starts the next opcode fetch immediately.
               if (INSTR_READY) begin
                  r_valid <= 1'b0;
                  if (w_is_halt) begin
                     r_halted <= 1'b1;
                  end else begin
                     r_ce   <= 1'b0;
                     r_abus <= r_pc;
                     r_cnt  <= '0;
                  end
               end
            end
            default: begin
               r_ce <= 1'b1;
            end
         endcase
      end
   end

   assign CE          = r_ce;
   assign ABUS        = r_abus;
   assign PC          = r_pc;
   assign INSTR_VALID = r_valid;
   assign OPCODE      = r_opcode;
   assign OPERAND     = r_operand;
   assign HALTED      = r_halted;
   assign ERROR       = r_error;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: ROM models on the bus, scoreboard of expected
// opcode/operand pairs, one task per scenario.
module tb_rom_fetch_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N, START, START3, READY, READY3;
   logic       CE, CE3, VALID, VALID3;
   logic       HALTED, HALTED3, ERROR, ERROR3;
   logic [3:0] ABUS, ABUS3, PC, PC3;
   logic [7:0] DBUS, DBUS3;
   logic [7:0] OPCODE, OPERAND, OPCODE3, OPERAND3;

   logic [7:0]  rom  [16];
   logic [7:0]  rom3 [16];
   int          age3 = 0;
   logic [3:0]  last_a3 = 4'h0;
   logic        last_ce3 = 1'b1;
   logic [15:0] sb [$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 CLK = ~CLK;

   assign DBUS  = rom[ABUS];
   // Slow-ROM stub: 00 for two cycles after any bus change, real data after.
   assign DBUS3 = (age3 < 2) ? 8'h00 : rom3[ABUS3];

   always @(negedge CLK) begin
      last_a3  <= ABUS3;
      last_ce3 <= CE3;
      if (ABUS3 != last_a3 || CE3 != last_ce3) age3 <= 0;
      else if (age3 < 100)                     age3 <= age3 + 1;
   end

   rom_fetch_ctrl #(.AW(4), .DW(8), .WAIT_CYCLES(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .CE(CE), .ABUS(ABUS),
      .DBUS(DBUS), .INSTR_VALID(VALID), .INSTR_READY(READY),
      .OPCODE(OPCODE), .OPERAND(OPERAND), .PC(PC),
      .HALTED(HALTED), .ERROR(ERROR)
   );

   rom_fetch_ctrl #(.AW(4), .DW(8), .WAIT_CYCLES(3)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .START(START3), .CE(CE3), .ABUS(ABUS3),
      .DBUS(DBUS3), .INSTR_VALID(VALID3), .INSTR_READY(READY3),
      .OPCODE(OPCODE3), .OPERAND(OPERAND3), .PC(PC3),
      .HALTED(HALTED3), .ERROR(ERROR3)
   );

   task automatic load_std;
      logic [7:0] prog [16];
      prog = '{8'hFF, 8'h05, 8'hFE, 8'h04, 8'hFD, 8'h03, 8'hFC, 8'h06,
               8'hFB, 8'h01, 8'hF2, 8'h01, 8'hF9, 8'h01, 8'hF8, 8'h00};
      for (int i = 0; i < 16; i++) begin
         rom[i]  = prog[i];
         rom3[i] = prog[i];
      end
   endtask

   task automatic push_std;
      sb.push_back(16'hFF05); sb.push_back(16'hFE04);
      sb.push_back(16'hFD03); sb.push_back(16'hFC06);
      sb.push_back(16'hFB01); sb.push_back(16'hF201);
      sb.push_back(16'hF901); sb.push_back(16'hF800);
   endtask

   task automatic do_reset;
      @(negedge CLK);
      RST_N = 1'b0; START = 1'b0; START3 = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      sb.delete();
   endtask

   task automatic pulse_start;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic test_reset;
      load_std();
      RST_N = 1'b0; START = 1'b0; START3 = 1'b0;
      READY = 1'b0; READY3 = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_vec++;
      if ({CE, ABUS, PC, VALID, OPCODE, OPERAND, HALTED, ERROR} !==
          {1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_w1: got ce=%b abus=%h pc=%h v=%b op=%h arg=%h h=%b e=%b want 1 0 0 0 00 00 0 0",
                  CE, ABUS, PC, VALID, OPCODE, OPERAND, HALTED, ERROR);
      end
      n_vec++;
      if ({CE3, ABUS3, PC3, VALID3, HALTED3, ERROR3} !==
          {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_w3: got ce=%b abus=%h pc=%h v=%b h=%b e=%b want 1 0 0 0 0 0",
                  CE3, ABUS3, PC3, VALID3, HALTED3, ERROR3);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_program;
      logic [15:0] exp;
      int first, second;
      first = -1; second = -1;
      load_std();
      do_reset();
      READY = 1'b1;
      push_std();
      pulse_start();
      for (int i = 1; i <= 60 && sb.size() > 0; i++) begin
         @(negedge CLK);
         if (VALID) begin
            exp = sb.pop_front();
            n_vec++;
            if ({OPCODE, OPERAND} !== exp) begin
               n_err++;
               $display("FAIL prog_pair: got %h,%h want %h,%h",
                        OPCODE, OPERAND, exp[15:8], exp[7:0]);
            end
            if (first < 0)       first = i;
            else if (second < 0) second = i;
         end
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL prog_timeout: %0d pairs left want 0", sb.size());
      end
      n_vec++;
      if (first != 2) begin
         n_err++;
         $display("FAIL prog_latency: got %0d edges want 2", first);
      end
      n_vec++;
      if (second - first != 3) begin
         n_err++;
         $display("FAIL prog_throughput: got %0d cycles want 3", second - first);
      end
      @(negedge CLK);
      n_vec++;
      if ({HALTED, ERROR, PC, CE} !== {1'b1, 1'b0, 4'hF, 1'b1}) begin
         n_err++;
         $display("FAIL prog_halt: got h=%b e=%b pc=%h ce=%b want 1 0 f 1",
                  HALTED, ERROR, PC, CE);
      end
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         n_vec++;
         if ({CE, VALID, HALTED} !== 3'b101) begin
            n_err++;
            $display("FAIL halt_sticky: got ce=%b v=%b h=%b want 1 0 1",
                     CE, VALID, HALTED);
         end
      end
   endtask

   task automatic test_stall;
      logic [15:0] exp;
      int seen;
      seen = 0;
      load_std();
      do_reset();
      READY = 1'b0;
      sb.push_back(16'hFF05);
      pulse_start();
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge CLK);
         if (VALID) seen = 1;
      end
      n_vec++;
      if (seen == 0) begin
         n_err++;
         $display("FAIL stall_timeout: valid=%b want 1", VALID);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         n_vec++;
         if ({VALID, OPCODE, OPERAND, CE, ABUS} !==
             {1'b1, 8'hFF, 8'h05, 1'b1, 4'h1}) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b op=%h arg=%h ce=%b abus=%h want 1 ff 05 1 1",
                     VALID, OPCODE, OPERAND, CE, ABUS);
         end
      end
      READY = 1'b1;
      exp = sb.pop_front();
      n_vec++;
      if ({OPCODE, OPERAND} !== exp) begin
         n_err++;
         $display("FAIL stall_pair: got %h,%h want %h,%h",
                  OPCODE, OPERAND, exp[15:8], exp[7:0]);
      end
      @(negedge CLK);
      n_vec++;
      if ({VALID, CE, ABUS} !== {1'b0, 1'b0, 4'h2}) begin
         n_err++;
         $display("FAIL stall_release: got v=%b ce=%b abus=%h want 0 0 2",
                  VALID, CE, ABUS);
      end
   endtask

   task automatic test_wait3;
      logic [15:0] exp;
      int at;
      at = -1;
      load_std();
      do_reset();
      READY3 = 1'b1;
      sb.push_back(16'hFF05);
      @(negedge CLK);
      START3 = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START3 = 1'b0;
      for (int i = 1; i <= 20 && at < 0; i++) begin
         @(negedge CLK);
         if (VALID3) begin
            at = i;
            exp = sb.pop_front();
            n_vec++;
            if ({OPCODE3, OPERAND3} !== exp) begin
               n_err++;
               $display("FAIL wait3_pair: got %h,%h want %h,%h",
                        OPCODE3, OPERAND3, exp[15:8], exp[7:0]);
            end
         end
      end
      n_vec++;
      if (at != 6) begin
         n_err++;
         $display("FAIL wait3_latency: got %0d edges want 6", at);
      end
      READY3 = 1'b0;
   endtask

   task automatic test_illegal;
      logic seen;
      seen = 1'b0;
      load_std();
      rom[0] = 8'h12;
      do_reset();
      READY = 1'b1;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         seen = seen | VALID;
      end
      n_vec++;
      if ({ERROR, HALTED, CE, OPCODE} !== {1'b1, 1'b0, 1'b1, 8'h12}) begin
         n_err++;
         $display("FAIL illegal_err: got e=%b h=%b ce=%b op=%h want 1 0 1 12",
                  ERROR, HALTED, CE, OPCODE);
      end
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         seen = seen | VALID;
      end
      n_vec++;
      if ({ERROR, CE, PC, seen} !== {1'b1, 1'b1, 4'h1, 1'b0}) begin
         n_err++;
         $display("FAIL illegal_sticky: got e=%b ce=%b pc=%h seen_valid=%b want 1 1 1 0",
                  ERROR, CE, PC, seen);
      end
      load_std();
   endtask

   task automatic test_reset_mid;
      logic [15:0] exp;
      int seen;
      seen = 0;
      load_std();
      do_reset();
      READY = 1'b1;
      pulse_start();
      repeat (4) @(negedge CLK);
      n_vec++;
      if ({CE, ABUS} !== {1'b0, 4'h3}) begin
         n_err++;
         $display("FAIL mid_setup: got ce=%b abus=%h want 0 3", CE, ABUS);
      end
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      n_vec++;
      if ({CE, PC, VALID, OPCODE} !== {1'b1, 4'h0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL mid_reset: got ce=%b pc=%h v=%b op=%h want 1 0 0 00",
                  CE, PC, VALID, OPCODE);
      end
      sb.push_back(16'hFF05);
      pulse_start();
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge CLK);
         if (VALID) begin
            seen = 1;
            exp = sb.pop_front();
            n_vec++;
            if ({OPCODE, OPERAND} !== exp) begin
               n_err++;
               $display("FAIL mid_refetch: got %h,%h want %h,%h",
                        OPCODE, OPERAND, exp[15:8], exp[7:0]);
            end
         end
      end
      n_vec++;
      if (seen == 0) begin
         n_err++;
         $display("FAIL mid_timeout: valid=%b want 1", VALID);
      end
   endtask

   task automatic test_wrap;
      logic [15:0] exp;
      int cnt;
      cnt = 0;
      for (int i = 0; i < 16; i++)
         rom[i] = (i % 2 == 0) ? 8'hFF : 8'(8'h30 + i);
      do_reset();
      READY = 1'b1;
      for (int i = 1; i < 16; i += 2)
         sb.push_back({8'hFF, 8'(8'h30 + i)});
      pulse_start();
      for (int i = 0; i < 60 && sb.size() > 0; i++) begin
         @(negedge CLK);
         if (VALID) begin
            cnt++;
            exp = sb.pop_front();
            n_vec++;
            if ({OPCODE, OPERAND} !== exp) begin
               n_err++;
               $display("FAIL wrap_pair%0d: got %h,%h want %h,%h",
                        cnt, OPCODE, OPERAND, exp[15:8], exp[7:0]);
            end
            if (cnt == 8) begin
               n_vec++;
               if (PC !== 4'h0) begin
                  n_err++;
                  $display("FAIL wrap_pc: got %h want 0", PC);
               end
            end
         end
      end
      n_vec++;
      if (cnt != 8) begin
         n_err++;
         $display("FAIL wrap_count: got %0d issues want 8", cnt);
      end
      @(negedge CLK);
      n_vec++;
      if ({CE, ABUS, ERROR, HALTED} !== {1'b0, 4'h0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL wrap_ninth: got ce=%b abus=%h e=%b h=%b want 0 0 0 0",
                  CE, ABUS, ERROR, HALTED);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_stall();
      test_wait3();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
